// File: rtl/ram_loader.sv
// Runtime memory loader: packs an MSB-first byte stream into 32-bit words and
// writes them to instruction or data memory, holding the selected pipeline stage.
module ram_loader #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 9
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              target,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [CNT_W-1:0]  word_count,
    input  logic              abort,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              fetch_ram_load,
    output logic              mem_ram_load,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

    state_t            state, state_next;
    logic              target_q;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  remaining;
    logic [23:0]       word;
    logic [1:0]        byte_idx;
    logic              accept;
    logic              tgt_next;
    logic              busy_next;

    assign accept = (state == RECV) && byte_valid && !abort;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start) state_next = (word_count == '0) ? DONE : RECV;
            RECV: begin
                if (abort)                            state_next = IDLE;
                else if (byte_valid && byte_idx == 2'd3) state_next = WRITE;
            end
            WRITE: begin
                if (abort)                            state_next = IDLE;
                else if (remaining == CNT_W'(1))      state_next = DONE;
                else                                  state_next = RECV;
            end
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next-state decode so they line up with the state they describe.
    assign tgt_next  = (state == IDLE && start) ? target : target_q;
    assign busy_next = (state_next == RECV) || (state_next == WRITE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            target_q       <= 1'b0;
            addr           <= '0;
            remaining      <= '0;
            word           <= '0;
            byte_idx       <= '0;
            byte_ready     <= 1'b0;
            fetch_ram_load <= 1'b0;
            mem_ram_load   <= 1'b0;
            ram_we         <= 1'b0;
            ram_addr       <= '0;
            ram_wdata      <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            state          <= state_next;
            target_q       <= tgt_next;
            byte_ready     <= (state_next == RECV);
            busy           <= busy_next;
            done           <= (state_next == DONE);
            fetch_ram_load <= busy_next & ~tgt_next;
            mem_ram_load   <= busy_next &  tgt_next;
            ram_we         <= (state_next == WRITE);
            ram_addr       <= (state_next == WRITE) ? addr : '0;
            ram_wdata      <= (state_next == WRITE) ? {word, byte_in} : '0;

            if (state == IDLE && start) begin
                addr      <= start_addr;
                remaining <= word_count;
                word      <= '0;
                byte_idx  <= '0;
            end
            if (accept) begin
                word     <= {word[15:0], byte_in};
                byte_idx <= byte_idx + 2'd1;
            end
            if (state == WRITE && !abort) begin
                addr      <= addr + ADDR_W'(1);
                remaining <= remaining - CNT_W'(1);
            end
        end
    end

endmodule
